serial_tx_scheduler: RTL and testbench

Shares the single outgoing board-link serial channel between NUM_REQ on-chip message requesters, such as the processor move-sender and the status reporter. Each cycle in IDLE it picks one pending request round-robin. It then frames the request as a 4-bit opcode followed by an opcode-dependent number of payload bits, and shifts the frame out MSB-first on a generated serial clock/data pair. The frame format is the one the link receiver samples on its serial-clock rising edge.

---
 rtl/serial_link_pkg.sv | 40 ++++
 rtl/serial_tx_scheduler_if.sv | 34 +++
 rtl/rr_arbiter.sv | 47 ++++
 rtl/serial_tx_scheduler.sv | 144 ++++++++++++++
 tb/tb_serial_tx_scheduler.sv | 302 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/serial_link_pkg.sv
`default_nettype none
// ============================================================================
// Module      : serial_link_pkg
// Description : Board-link framing constants and opcode length lookup, shared
//               by the transmit scheduler and the link receiver.
// Revision    : 1.0 - initial release
// ============================================================================
package serial_link_pkg;

    localparam int OPCODE_W      = 4;
    localparam int MAX_PAYLOAD_W = 27;
    localparam int FRAME_W       = OPCODE_W + MAX_PAYLOAD_W;
    localparam int BITCNT_W      = 5;
    localparam int GRANT_W       = 3;

    typedef logic [OPCODE_W-1:0] opcode_t;

    localparam opcode_t OP_VALID_MOVE  = 4'd0;
    localparam opcode_t OP_STATUS      = 4'd1;
    localparam opcode_t OP_BOARD_RESET = 4'd2;

    typedef logic [1:0] tx_state_t;

    localparam tx_state_t ST_IDLE = 2'd0;
    localparam tx_state_t ST_LOW  = 2'd1;
    localparam tx_state_t ST_HIGH = 2'd2;
    localparam tx_state_t ST_GAP  = 2'd3;

    // Payload bit count for an opcode; -1 marks an undefined opcode.
    function automatic int payload_length(input opcode_t opcode);
        case (opcode)
            OP_VALID_MOVE:  payload_length = 10;
            OP_STATUS:      payload_length = 4;
            OP_BOARD_RESET: payload_length = 0;
            default:        payload_length = -1;
        endcase
    endfunction

endpackage
`default_nettype wire

// File: rtl/serial_tx_scheduler_if.sv
`default_nettype none
// ============================================================================
// Module      : serial_tx_scheduler_if
// Description : Requester handshake, status and serial link signals of the
//               transmit scheduler.
// Revision    : 1.0 - initial release
// ============================================================================
interface serial_tx_scheduler_if #(
    parameter int NUM_REQ = 2
);
    import serial_link_pkg::*;

    logic [NUM_REQ-1:0]               req_valid;
    logic [OPCODE_W*NUM_REQ-1:0]      req_opcode;
    logic [MAX_PAYLOAD_W*NUM_REQ-1:0] req_payload;
    logic [NUM_REQ-1:0]               req_ready;
    logic [GRANT_W-1:0]               grant_id;
    logic                             busy;
    logic                             err_bad_opcode;
    logic                             ser_clock_out;
    logic                             ser_data_out;

    modport master (
        output req_valid, req_opcode, req_payload,
        input  req_ready, grant_id, busy, err_bad_opcode, ser_clock_out, ser_data_out
    );

    modport slave (
        input  req_valid, req_opcode, req_payload,
        output req_ready, grant_id, busy, err_bad_opcode, ser_clock_out, ser_data_out
    );

endinterface
`default_nettype wire

// File: rtl/rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : rr_arbiter
// Description : Combinational round-robin pick of the first request at or
//               above the pointer, wrapping; pointer storage lives outside.
// Revision    : 1.0 - initial release
// ============================================================================
module rr_arbiter #(
    parameter int NUM_REQ = 2
) (
    input  wire logic [NUM_REQ-1:0] i_req,
    input  wire logic [2:0]         i_ptr,
    output logic      [NUM_REQ-1:0] o_grant,
    output logic      [2:0]         o_grant_idx,
    output logic                    o_any
);

    logic [2*NUM_REQ-1:0] w_req_dbl;
    logic [NUM_REQ-1:0]   w_rot;
    logic [3:0]           w_sum;

    assign o_any = |i_req;

    // Rotating the doubled vector puts the pointer slot at bit 0, so the
    // lowest set bit of w_rot is the winner.
    always_comb begin
        w_req_dbl   = {i_req, i_req};
        w_rot       = NUM_REQ'(w_req_dbl >> i_ptr);
        w_sum       = '0;
        o_grant_idx = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            if (w_rot[k]) begin
                w_sum = {1'b0, i_ptr} + 4'(k);
                if (w_sum >= 4'(NUM_REQ)) begin
                    w_sum = w_sum - 4'(NUM_REQ);
                end
                o_grant_idx = w_sum[2:0];
            end
        end
        o_grant = '0;
        for (int j = 0; j < NUM_REQ; j++) begin
            o_grant[j] = o_any && (o_grant_idx == 3'(j));
        end
    end

endmodule
`default_nettype wire

// File: rtl/serial_tx_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : serial_tx_scheduler
// Description : Round-robin sharing of the board-link serial channel; frames
//               {opcode, payload} MSB-first on a divided serial clock.
// Revision    : 1.0 - initial release
// ============================================================================
module serial_tx_scheduler
    import serial_link_pkg::*;
#(
    parameter int NUM_REQ    = 2,
    parameter int CLK_DIV    = 4,
    parameter int GAP_CYCLES = 16
) (
    input  wire logic            clock,
    input  wire logic            reset,
    serial_tx_scheduler_if.slave bus
);

    localparam int c_DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int c_GAP_W = $clog2(GAP_CYCLES + 1);

    tx_state_t              r_state;
    tx_state_t              w_state_nxt;
    logic [2:0]             r_ptr;
    logic [GRANT_W-1:0]     r_grant_id;
    logic [FRAME_W-1:0]     r_shift;
    logic [BITCNT_W-1:0]    r_bits;
    logic [c_DIV_W-1:0]     r_div;
    logic [c_GAP_W-1:0]     r_gap;

    logic [NUM_REQ-1:0]     w_grant;
    logic [2:0]             w_sel;
    logic                   w_any;
    opcode_t                w_opcode;
    logic [MAX_PAYLOAD_W-1:0] w_payload;
    int                     w_len;
    logic                   w_len_ok;
    logic                   w_accept;
    logic                   w_div_last;
    logic                   w_gap_last;
    logic [2:0]             w_next_ptr;
    logic [FRAME_W-1:0]     w_frame;

    rr_arbiter #(
        .NUM_REQ     (NUM_REQ)
    ) u_arb (
        .i_req       (bus.req_valid),
        .i_ptr       (r_ptr),
        .o_grant     (w_grant),
        .o_grant_idx (w_sel),
        .o_any       (w_any)
    );

    always_comb begin
        w_opcode  = '0;
        w_payload = '0;
        for (int j = 0; j < NUM_REQ; j++) begin
            if (w_sel == 3'(j)) begin
                w_opcode  = bus.req_opcode[OPCODE_W*j +: OPCODE_W];
                w_payload = bus.req_payload[MAX_PAYLOAD_W*j +: MAX_PAYLOAD_W];
            end
        end
    end

    // Shifting the payload up by (27-L) both MSB-aligns it and drops the
    // bits above L-1.
    assign w_len      = payload_length(w_opcode);
    assign w_len_ok   = (w_len >= 0);
    assign w_frame    = {w_opcode, w_payload << (MAX_PAYLOAD_W - w_len)};
    assign w_accept   = (r_state == ST_IDLE) && w_any && !reset;
    assign w_div_last = (r_div == c_DIV_W'(CLK_DIV - 1));
    assign w_gap_last = (r_gap == c_GAP_W'(GAP_CYCLES - 1));
    assign w_next_ptr = (w_sel == 3'(NUM_REQ - 1)) ? 3'd0 : (w_sel + 3'd1);

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: if (w_accept && w_len_ok) w_state_nxt = ST_LOW;
            ST_LOW:  if (w_div_last)           w_state_nxt = ST_HIGH;
            ST_HIGH: if (w_div_last)           w_state_nxt = (r_bits == BITCNT_W'(1)) ? ST_GAP : ST_LOW;
            ST_GAP:  if (w_gap_last)           w_state_nxt = ST_IDLE;
            default:                           w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_ptr      <= '0;
            r_grant_id <= '0;
            r_shift    <= '0;
            r_bits     <= '0;
            r_div      <= '0;
            r_gap      <= '0;
        end else begin
            if (w_accept) begin
                r_ptr      <= w_next_ptr;
                r_grant_id <= w_sel;
                if (w_len_ok) begin
                    r_shift <= w_frame;
                    r_bits  <= BITCNT_W'(OPCODE_W + w_len);
                end
            end
            if (r_state == ST_LOW || r_state == ST_HIGH) begin
                r_div <= w_div_last ? '0 : r_div + 1'b1;
            end else begin
                r_div <= '0;
            end
            if (r_state == ST_HIGH && w_div_last) begin
                r_shift <= {r_shift[FRAME_W-2:0], 1'b0};
                r_bits  <= r_bits - 1'b1;
            end
            if (r_state == ST_GAP) begin
                r_gap <= r_gap + 1'b1;
            end else begin
                r_gap <= '0;
            end
        end
    end

    always_comb begin
        bus.req_ready      = '0;
        bus.err_bad_opcode = 1'b0;
        bus.grant_id       = r_grant_id;
        bus.busy           = (r_state != ST_IDLE);
        bus.ser_clock_out  = (r_state == ST_HIGH);
        bus.ser_data_out   = (r_state == ST_LOW || r_state == ST_HIGH) && r_shift[FRAME_W-1];
        if (w_accept) begin
            bus.req_ready      = w_grant;
            bus.grant_id       = w_sel;
            bus.err_bad_opcode = !w_len_ok;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_serial_tx_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : tb_serial_tx_scheduler
// Description : Directed scoreboard bench for serial_tx_scheduler.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_serial_tx_scheduler;
    import serial_link_pkg::*;

    localparam int NUM_REQ    = 2;
    localparam int CLK_DIV    = 2;
    localparam int GAP_CYCLES = 16;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    serial_tx_scheduler_if #(.NUM_REQ(NUM_REQ)) bus ();

    serial_tx_scheduler #(
        .NUM_REQ    (NUM_REQ),
        .CLK_DIV    (CLK_DIV),
        .GAP_CYCLES (GAP_CYCLES)
    ) dut (
        .clock (clk),
        .reset (rst),
        .bus   (bus)
    );

    typedef struct { logic [2:0] id; logic err; int min_space; } acc_t;
    typedef struct { int nbits; logic [30:0] bits; int busy_len; } frm_t;

    acc_t acc_q[$];
    frm_t frm_q[$];

    int n_vec    = 0;
    int n_err    = 0;
    int cyc      = 0;
    int idle_bad = 0;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, got, exp, cyc);
        end
    endtask

    task automatic push_acc(input logic [2:0] id, input logic err, input int min_space);
        acc_t a;
        a.id = id; a.err = err; a.min_space = min_space;
        acc_q.push_back(a);
    endtask

    task automatic push_frm(input int nbits, input logic [30:0] bits, input int busy_len);
        frm_t f;
        f.nbits = nbits; f.bits = bits; f.busy_len = busy_len;
        frm_q.push_back(f);
    endtask

    task automatic set_req(input int i, input logic v, input logic [3:0] op, input logic [26:0] pl);
        bus.req_valid[i]             = v;
        bus.req_opcode[4*i +: 4]     = op;
        bus.req_payload[27*i +: 27]  = pl;
    endtask

    // Requester behaviour: hold until ready is seen, then drop valid.
    task automatic wait_ready(input int i, input int limit);
        int n = 0;
        while (1) begin
            @(negedge clk);
            if (bus.req_ready[i]) break;
            n++;
            if (n >= limit) begin
                chk($sformatf("ready[%0d] timeout", i), 32'(bus.req_ready[i]), 32'd1);
                break;
            end
        end
        @(posedge clk); #1;
        bus.req_valid[i] = 1'b0;
    endtask

    task automatic wait_idle(input int limit);
        int n = 0;
        @(posedge clk); #1;
        while (1) begin
            @(negedge clk);
            if (!bus.busy) break;
            n++;
            if (n >= limit) begin
                chk("busy timeout", 32'(bus.busy), 32'd0);
                break;
            end
        end
        @(posedge clk); #1;
    endtask

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // Accept monitor
    initial begin
        acc_t a;
        int   last_acc = -1000;
        int   d;
        forever begin
            @(negedge clk);
            if (bus.req_ready != '0) begin
                if (acc_q.size() == 0) begin
                    chk("unexpected accept", 32'(bus.req_ready), 32'd0);
                end else begin
                    a = acc_q.pop_front();
                    chk("req_ready onehot", 32'(bus.req_ready), 32'd1 << a.id);
                    chk("grant_id", 32'(bus.grant_id), 32'(a.id));
                    chk("err_bad_opcode", 32'(bus.err_bad_opcode), 32'(a.err));
                    chk("busy at accept", 32'(bus.busy), 32'd0);
                    if (a.min_space > 0) begin
                        d = cyc - last_acc;
                        chk("accept spacing", (d >= a.min_space) ? a.min_space : d, a.min_space);
                    end
                end
                last_acc = cyc;
            end else if (bus.err_bad_opcode) begin
                chk("err without ready", 32'(bus.err_bad_opcode), 32'd0);
            end
        end
    end

    // Frame monitor
    initial begin
        frm_t        f;
        logic        prev_busy = 1'b0;
        logic        prev_sclk = 1'b0;
        int          f_edges   = 0;
        int          f_busy    = 0;
        int          f_start   = 0;
        int          f_last    = 0;
        logic [30:0] f_bits    = '0;
        forever begin
            @(negedge clk);
            if (bus.busy && !prev_busy) begin
                f_edges = 0; f_busy = 0; f_bits = '0; f_start = cyc;
            end
            if (bus.busy) f_busy++;
            else if (bus.ser_clock_out || bus.ser_data_out) idle_bad++;
            if (bus.ser_clock_out && !prev_sclk) begin
                f_edges++;
                f_bits = {f_bits[29:0], bus.ser_data_out};
                if (f_edges == 1) chk("first edge delay", cyc - f_start, CLK_DIV);
                else              chk("edge spacing", cyc - f_last, 2 * CLK_DIV);
                f_last = cyc;
            end
            if (!bus.busy && prev_busy) begin
                if (frm_q.size() == 0) begin
                    chk("unexpected frame", f_busy, 0);
                end else begin
                    f = frm_q.pop_front();
                    chk("frame edges", f_edges, f.nbits);
                    chk("frame bits", 32'(f_bits), 32'(f.bits));
                    if (f.busy_len >= 0) chk("busy length", f_busy, f.busy_len);
                end
            end
            prev_busy = bus.busy;
            prev_sclk = bus.ser_clock_out;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached, acc_q=%0d frm_q=%0d", acc_q.size(), frm_q.size());
        $fatal(1, "watchdog");
    end

    initial begin
        int   seen;
        int   n;
        int   edges;
        logic prev;

        bus.req_valid   = '0;
        bus.req_opcode  = '0;
        bus.req_payload = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset outputs", 32'({bus.req_ready, bus.grant_id, bus.busy, bus.err_bad_opcode,
                                  bus.ser_clock_out, bus.ser_data_out}), 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;

        // Valid move, 14-bit frame
        push_acc(3'd0, 1'b0, 0);
        push_frm(14, 31'b0000_1010100101, 72);
        set_req(0, 1'b1, OP_VALID_MOVE, 27'h2A5);
        wait_ready(0, 20);
        wait_idle(200);

        // Undefined opcode from req1, then status from req0 with junk upper payload
        push_acc(3'd1, 1'b1, 0);
        push_acc(3'd0, 1'b0, 0);
        push_frm(8, 31'b0001_0011, 48);
        set_req(1, 1'b1, 4'hF, 27'h0);
        set_req(0, 1'b1, OP_STATUS, 27'h7FFFFF3);
        wait_ready(1, 20);
        @(negedge clk);
        chk("accept after bad opcode", 32'(bus.req_ready), 32'd1);
        @(posedge clk); #1;
        bus.req_valid[0] = 1'b0;
        wait_idle(200);

        // Two continuous requesters after reset alternate
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        push_acc(3'd0, 1'b0, 0);
        push_acc(3'd1, 1'b0, 33);
        push_acc(3'd0, 1'b0, 33);
        push_acc(3'd1, 1'b0, 33);
        for (int k = 0; k < 4; k++) push_frm(4, 31'b0010, 32);
        set_req(0, 1'b1, OP_BOARD_RESET, 27'h0);
        set_req(1, 1'b1, OP_BOARD_RESET, 27'h0);
        seen = 0;
        n    = 0;
        while (seen < 4 && n < 400) begin
            @(negedge clk);
            if (bus.req_ready != '0) seen++;
            n++;
        end
        chk("four accepts seen", seen, 4);
        @(posedge clk); #1;
        bus.req_valid = '0;
        wait_idle(200);

        // Reset after the 6th rising edge of a valid-move frame
        push_acc(3'd0, 1'b0, 0);
        push_frm(6, 31'b0000_11, -1);
        set_req(0, 1'b1, OP_VALID_MOVE, 27'h3C1);
        wait_ready(0, 20);
        edges = 0;
        n     = 0;
        prev  = 1'b0;
        while (edges < 6 && n < 200) begin
            @(negedge clk);
            if (bus.ser_clock_out && !prev) edges++;
            prev = bus.ser_clock_out;
            n++;
        end
        chk("edges before reset", edges, 6);
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("outputs after mid-frame reset", 32'({bus.req_ready, bus.grant_id, bus.busy,
                                  bus.err_bad_opcode, bus.ser_clock_out, bus.ser_data_out}), 32'd0);
        @(posedge clk); #1;
        push_acc(3'd0, 1'b0, 0);
        push_frm(4, 31'b0010, 32);
        push_acc(3'd1, 1'b0, 0);
        push_frm(4, 31'b0010, 32);
        push_acc(3'd1, 1'b0, 0);
        push_frm(8, 31'b0001_0101, 48);
        set_req(0, 1'b1, OP_BOARD_RESET, 27'h0);
        set_req(1, 1'b1, OP_BOARD_RESET, 27'h0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        chk("first accept after reset", 32'(bus.req_ready), 32'd1);
        @(posedge clk); #1;
        bus.req_valid[0] = 1'b0;

        // req0 withdraws one cycle before its turn; req1 must win
        n = 0;
        while (1) begin
            @(negedge clk);
            if (bus.req_ready[1]) break;
            n++;
            if (n >= 100) begin
                chk("ready[1] timeout", 32'(bus.req_ready[1]), 32'd1);
                break;
            end
        end
        @(posedge clk); #1;
        set_req(1, 1'b1, OP_STATUS, 27'h5);
        set_req(0, 1'b1, OP_BOARD_RESET, 27'h0);
        repeat (31) @(posedge clk);
        #1;
        bus.req_valid[0] = 1'b0;
        wait_ready(1, 20);
        wait_idle(200);

        repeat (4) @(posedge clk);
        chk("accept queue drained", acc_q.size(), 0);
        chk("frame queue drained", frm_q.size(), 0);
        chk("serial outputs low while idle", idle_bad, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
